// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg
// Constants shared by the instruction fetch front end.
//   FQ_RV32_NOP    : canonical RV32 NOP encoding (addi x0, x0, 0)
//   FQ_WORD_BYTES  : byte increment between consecutive fetch words
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam logic [31:0] FQ_RV32_NOP   = 32'h0000_0013;
    localparam int unsigned FQ_WORD_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with flush, used for the pc tag queue and the
// instruction queue of fetch_queue. The head is shown as zero when empty.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_flush          : empties the FIFO on the next edge
//   i_push, i_data   : write one entry
//   i_pop            : remove the head (ignored when empty)
//   o_head           : entry at the head, zero when empty
//   o_count          : number of stored entries, 0..DEPTH
//   o_full, o_empty  : status flags
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers are log2(DEPTH) bits; DEPTH is a power of two so they wrap freely.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_flush) assert (!(i_push && o_full));
    end

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction fetch front end. Issues pipelined word requests to an
// in-order instruction memory of arbitrary latency, buffers the returned
// words with their pc in a DEPTH-entry prefetch FIFO and hands them to
// decode with valid/ready. A redirect flushes the FIFO, restarts fetch at
// the new pc and discards every response still outstanding.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   req_valid/ready/addr     : fetch request channel to memory
//   rsp_valid, rsp_data      : in-order responses, no backpressure
//   ins_valid/ready          : handshake towards decode
//   ins_data, ins_pc         : instruction at FIFO head and its address
//   redirect, redirect_pc    : flush and restart fetch (pc bits [1:0] ignored)
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [XLEN-1:0]  req_addr,
    input  logic             rsp_valid,
    input  logic [XLEN-1:0]  rsp_data,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic [XLEN-1:0]  ins_data,
    output logic [XLEN-1:0]  ins_pc,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   r_fetch_pc;
    logic [CW-1:0]     r_drop_cnt;

    logic [CW-1:0]     w_tag_count;   // requests accepted but not yet answered
    logic              w_tag_full;
    logic              w_tag_empty;
    logic [XLEN-1:0]   w_tag_pc;
    logic [CW-1:0]     w_ins_count;
    logic              w_ins_full;
    logic              w_ins_empty;
    logic [2*XLEN-1:0] w_ins_head;
    logic [CW:0]       w_credit;
    logic              w_accept;
    logic              w_rsp;
    logic              w_ins_push;

    // One extra bit: count + inflight can momentarily reach 2*DEPTH.
    assign w_credit = {1'b0, w_ins_count} + {1'b0, w_tag_count} - {1'b0, r_drop_cnt};

    // The tag-queue check only matters while drops are pending: it keeps the
    // number of outstanding requests at DEPTH so the tag queue cannot overflow.
    assign req_valid = !reset && !redirect && !w_tag_full && (w_credit < (CW+1)'(DEPTH));
    assign req_addr  = r_fetch_pc;
    assign w_accept  = req_valid && req_ready;

    // A response with nothing outstanding is a leftover from before a reset.
    assign w_rsp      = rsp_valid && !w_tag_empty;
    assign w_ins_push = w_rsp && (r_drop_cnt == '0) && !redirect;

    assign ins_valid = !w_ins_empty;
    assign ins_pc    = w_ins_head[2*XLEN-1:XLEN];
    assign ins_data  = w_ins_head[XLEN-1:0];

    fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (1'b0),
        .i_push  (w_accept),
        .i_data  (r_fetch_pc),
        .i_pop   (w_rsp),
        .o_head  (w_tag_pc),
        .o_count (w_tag_count),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    fetch_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_ins_q (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (redirect),
        .i_push  (w_ins_push),
        .i_data  ({w_tag_pc, rsp_data}),
        .i_pop   (ins_ready),
        .o_head  (w_ins_head),
        .o_count (w_ins_count),
        .o_full  (w_ins_full),
        .o_empty (w_ins_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc & ~XLEN'(3);
            // Everything still outstanding after this cycle's response is stale.
            r_drop_cnt <= w_tag_count - CW'(w_rsp);
        end else begin
            if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(FQ_WORD_BYTES);
            if (w_rsp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(w_ins_push && w_ins_full));
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Bench for fetch_queue: an in-order memory model with configurable latency
// (mem[a] = a + 0x100), a queue of expected pcs pushed on each accepted
// request and popped when decode consumes an instruction, a table of
// traffic scenarios and hand-written redirect/stall/reset sequences.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          drop;
    } mreq_t;

    typedef struct {
        int          lat;
        int          rr_mode;      // 0 always, 1 toggle, 2 random
        int          ir_mode;      // 0 always, 1 toggle, 2 random 75%, 3 never
        int          ncyc;
        bit          use_redir;
        logic [31:0] redir_pc;
        logic [31:0] exp_first_pc;
        int          exp_min;
    } vec_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_pc = RESET_PC;
    int          cyc = 0;
    int          g_lat = 1;
    int          g_rr_mode = 0;
    int          g_ir_mode = 0;
    int          checks = 0;
    int          errors = 0;
    int          n_deliv = 0;
    logic [31:0] first_pc = '0;

    logic        s_req_valid, s_accept, s_pop, s_rsp, s_ins_valid;
    logic [31:0] s_req_addr;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    function automatic int fifo_cnt_model();
        int nd = 0;
        foreach (mem_q[i]) if (!mem_q[i].drop) nd++;
        return exp_q.size() - nd;
    endfunction

    // One clock cycle: drive at negedge, check just after, update the models.
    task automatic step(input logic rst_in, input logic redir_in, input logic [31:0] redir_pc_in);
        int          fcnt;
        logic        exp_rv;
        int          due;
        @(negedge clk);
        reset       = rst_in;
        redirect    = redir_in;
        redirect_pc = redir_pc_in;
        case (g_rr_mode)
            0:       req_ready = 1'b1;
            1:       req_ready = cyc[0];
            default: req_ready = 1'($urandom_range(0, 1));
        endcase
        case (g_ir_mode)
            0:       ins_ready = 1'b1;
            1:       ins_ready = cyc[0];
            2:       ins_ready = ($urandom_range(0, 3) != 0);
            default: ins_ready = 1'b0;
        endcase
        rsp_valid = !rst_in && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rsp_data  = rsp_valid ? mem_q[0].addr + 32'h100 : 32'hDEAD_BEEF;
        #1;
        fcnt   = fifo_cnt_model();
        exp_rv = !rst_in && !redir_in && (exp_q.size() < DEPTH) && (mem_q.size() < DEPTH);
        chk1("req_valid", req_valid, exp_rv);
        if (exp_rv) chk32("req_addr", req_addr, m_pc);
        chk1("ins_valid", ins_valid, fcnt > 0);
        if (fcnt > 0) begin
            chk32("ins_pc", ins_pc, exp_q[0]);
            chk32("ins_data", ins_data, exp_q[0] + 32'h100);
        end else begin
            chk32("ins_pc_empty", ins_pc, 32'h0);
            chk32("ins_data_empty", ins_data, 32'h0);
        end
        s_req_valid = req_valid;
        s_req_addr  = req_addr;
        s_accept    = req_valid && req_ready;
        s_pop       = ins_valid && ins_ready;
        s_rsp       = rsp_valid;
        s_ins_valid = ins_valid;
        if (rst_in) begin
            exp_q.delete();
            mem_q.delete();
            m_pc = RESET_PC;
        end else begin
            if (rsp_valid) void'(mem_q.pop_front());
            if (ins_ready && fcnt > 0) begin
                if (n_deliv == 0) first_pc = exp_q[0];
                n_deliv++;
                void'(exp_q.pop_front());
            end
            if (redir_in) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].drop = 1'b1;
                m_pc = redir_pc_in & ~32'h3;
            end else if (exp_rv && req_ready) begin
                due = cyc + g_lat;
                if (mem_q.size() > 0 && mem_q[$].due >= due) due = mem_q[$].due + 1;
                exp_q.push_back(m_pc);
                mem_q.push_back('{addr: m_pc, due: due, drop: 1'b0});
                m_pc = m_pc + 32'h4;
            end
        end
        cyc++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   n_acc;
        int   k;
        vecs[0] = '{lat: 1, rr_mode: 0, ir_mode: 0, ncyc: 40, use_redir: 1'b0,
                    redir_pc: 32'h0, exp_first_pc: 32'h0000_0000, exp_min: 30};
        vecs[1] = '{lat: 3, rr_mode: 1, ir_mode: 0, ncyc: 60, use_redir: 1'b0,
                    redir_pc: 32'h0, exp_first_pc: 32'h0000_0000, exp_min: 20};
        vecs[2] = '{lat: 2, rr_mode: 2, ir_mode: 2, ncyc: 80, use_redir: 1'b1,
                    redir_pc: 32'h0000_1003, exp_first_pc: 32'h0000_1000, exp_min: 10};
        vecs[3] = '{lat: 5, rr_mode: 0, ir_mode: 1, ncyc: 60, use_redir: 1'b1,
                    redir_pc: 32'hFFFF_FFF6, exp_first_pc: 32'hFFFF_FFF4, exp_min: 15};

        repeat (2) @(posedge clk);

        // Table-driven traffic scenarios.
        foreach (vecs[v]) begin
            g_lat = vecs[v].lat; g_rr_mode = vecs[v].rr_mode; g_ir_mode = vecs[v].ir_mode;
            step(1'b1, 1'b0, 32'h0);
            if (vecs[v].use_redir) step(1'b0, 1'b1, vecs[v].redir_pc);
            n_deliv = 0;
            for (int c = 0; c < vecs[v].ncyc; c++) step(1'b0, 1'b0, 32'h0);
            chk32("vec_first_pc", first_pc, vecs[v].exp_first_pc);
            chk1("vec_throughput", n_deliv >= vecs[v].exp_min, 1'b1);
        end

        // Consumer stalled: exactly DEPTH requests, then a new request the
        // cycle after the first pop.
        g_lat = 1; g_rr_mode = 0; g_ir_mode = 3;
        step(1'b1, 1'b0, 32'h0);
        n_acc = 0;
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 1'b0, 32'h0);
            if (s_accept) n_acc++;
        end
        chk32("stall_accepts", 32'(n_acc), 32'd4);
        chk1("stall_req_valid", s_req_valid, 1'b0);
        chk1("stall_full_valid", s_ins_valid, 1'b1);
        g_ir_mode = 0;
        step(1'b0, 1'b0, 32'h0);
        chk1("pop_cycle_pop", s_pop, 1'b1);
        chk1("pop_cycle_req_valid", s_req_valid, 1'b0);
        step(1'b0, 1'b0, 32'h0);
        chk1("after_pop_req_valid", s_req_valid, 1'b1);
        chk32("after_pop_req_addr", s_req_addr, 32'h0000_0010);

        // Redirect with three requests in flight.
        g_lat = 6; g_rr_mode = 0; g_ir_mode = 0;
        step(1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 32'h0);
        chk32("redir_inflight", 32'(mem_q.size()), 32'd3);
        n_deliv = 0;
        step(1'b0, 1'b1, 32'h0000_0203);
        chk1("redir_req_valid", s_req_valid, 1'b0);
        step(1'b0, 1'b0, 32'h0);
        chk1("redir_next_valid", s_req_valid, 1'b1);
        chk32("redir_next_addr", s_req_addr, 32'h0000_0200);
        k = 0;
        while (n_deliv == 0 && k < 60) begin step(1'b0, 1'b0, 32'h0); k++; end
        chk1("redir_deliver_in_time", n_deliv > 0, 1'b1);
        chk32("redir_first_pc", first_pc, 32'h0000_0200);

        // Redirect in the same cycle as a response and a pop.
        g_lat = 3; g_rr_mode = 0; g_ir_mode = 0;
        step(1'b1, 1'b0, 32'h0);
        k = 0;
        while (!(mem_q.size() > 0 && mem_q[0].due <= cyc && fifo_cnt_model() > 0) && k < 30) begin
            step(1'b0, 1'b0, 32'h0);
            k++;
        end
        chk1("same_cycle_found", k < 30, 1'b1);
        n_deliv = 0;
        step(1'b0, 1'b1, 32'h0000_0400);
        chk1("same_cycle_rsp_pop", s_rsp && s_pop, 1'b1);
        chk32("same_cycle_delivered", 32'(n_deliv), 32'd1);
        n_deliv = 0;
        step(1'b0, 1'b0, 32'h0);
        chk1("same_cycle_next_valid", s_req_valid, 1'b1);
        chk32("same_cycle_next_addr", s_req_addr, 32'h0000_0400);
        k = 0;
        while (n_deliv == 0 && k < 60) begin step(1'b0, 1'b0, 32'h0); k++; end
        chk32("same_cycle_first_pc", first_pc, 32'h0000_0400);

        // Reset mid-stream with two entries buffered.
        g_lat = 1; g_rr_mode = 0; g_ir_mode = 3;
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0800);
        k = 0;
        while (fifo_cnt_model() != 2 && k < 10) begin step(1'b0, 1'b0, 32'h0); k++; end
        chk32("midreset_fifo_two", 32'(fifo_cnt_model()), 32'd2);
        step(1'b1, 1'b0, 32'h0);
        chk1("midreset_req_valid", s_req_valid, 1'b0);
        g_ir_mode = 0;
        n_deliv = 0;
        step(1'b0, 1'b0, 32'h0);
        chk1("midreset_ins_valid", s_ins_valid, 1'b0);
        chk1("midreset_restart_valid", s_req_valid, 1'b1);
        chk32("midreset_restart_addr", s_req_addr, RESET_PC);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 32'h0);
        chk32("midreset_first_pc", first_pc, RESET_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end for the next-generation core.
- Replaces the combinational `imem_addr = pc_nxt` path, which assumes a zero-wait instruction memory.
- Issues pipelined word requests to an instruction memory of arbitrary latency that answers in order.
- Buffers returned instructions in a DEPTH-entry prefetch FIFO and presents them to decode with a valid/ready handshake.
- Supports redirect (branch/jump) with flush and discard of in-flight responses.

Parameters:
- XLEN, 32, address and instruction width.
- DEPTH, 4, prefetch FIFO entries and also the maximum number of in-flight requests; power of two, minimum 2.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- req_valid  output  1  fetch request valid.
- req_ready  input  1  memory accepts request this cycle.
- req_addr  output  XLEN  word-aligned fetch address.
- rsp_valid  input  1  memory returns one instruction; in order; no backpressure.
- rsp_data  input  XLEN  returned instruction word.
- ins_valid  output  1  FIFO head valid.
- ins_ready  input  1  decode consumes head.
- ins_data  output  XLEN  instruction at FIFO head.
- ins_pc  output  XLEN  address of that instruction.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored (treated as 0).

Behaviour:
- Reset (synchronous, wins over all other inputs):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; drop_cnt=0.
  - req_valid=0 during the reset cycle.
  - ins_valid=0; ins_data and ins_pc read 0.
- Reset during outstanding requests: the memory's late responses are not tracked and are ignored; the memory side must also be reset.
- State:
  - fetch_pc.
  - FIFO of {pc, data} with count 0..DEPTH.
  - inflight, 0..DEPTH: requests accepted but not yet answered.
  - drop_cnt, 0..inflight: responses to discard.
- Request issue:
  - req_valid = !reset && !redirect && (count + inflight - drop_cnt < DEPTH).
  - The credit check is conservative: a same-cycle pop does not free a credit.
  - req_addr = fetch_pc.
  - A request is accepted on req_valid && req_ready: fetch_pc += 4 (wraps modulo 2^XLEN) and inflight += 1.
  - Each accepted request also pushes its pc into a DEPTH-deep pc tag queue consumed by responses.
- Response:
  - On rsp_valid: inflight -= 1 and the pc tag is popped.
  - If drop_cnt>0, the data is discarded and drop_cnt -= 1.
  - Otherwise {tag pc, rsp_data} is pushed into the FIFO.
  - The credit rule guarantees the FIFO is never full at a push; a push-when-full is an assertion failure.
  - Latency: a response on cycle N gives ins_valid on cycle N+1 (registered FIFO, no bypass).
- Consume: ins_valid && ins_ready pops the head. Simultaneous push and pop keeps count unchanged.
- Redirect (any cycle, reset excepted):
  - Next cycle: FIFO empty and fetch_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt <= inflight - rsp_valid, so every request still outstanding is discarded.
  - A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle still happens; the consumer owns that instruction.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Memory pins:
  - req_addr must stay stable while req_valid && !req_ready, unless redirect or reset occurs.
  - Memory responses may arrive any number of cycles ≥1 after acceptance.
- Pointers are log2(DEPTH) bits and wrap naturally. inflight and count are log2(DEPTH)+1 bits.

Decomposition:
- Shared include, next to the existing header: RV32 NOP constant 32'h00000013 and the word-size increment constant 4.
- One sub-module: fetch_fifo, a parametrised synchronous FIFO with flush, count, full and empty.
  - Instantiated twice: the pc tag queue (XLEN wide) and the instruction queue (2*XLEN wide).
- All credit and drop logic stays in fetch_queue.

Test Plan:
- Zero-wait memory (req_ready=1, rsp one cycle later, mem[a]=a+32'h100), ins_ready=1 → after reset, ins_pc=0,4,8,… on consecutive cycles with ins_data=ins_pc+32'h100; no bubbles after the fill.
- Stall the consumer (ins_ready=0), DEPTH=4 → exactly 4 requests accepted (addresses 0..C), then req_valid=0 and count=4; after ins_ready=1 a new request is issued the cycle after the first pop.
- Memory latency 3 with req_ready toggling 1/0 → req_addr held while stalled; order preserved; ins_pc strictly +4.
- Redirect to 32'h00000203 while 3 requests are in flight → next fetch addr is 32'h00000200; the 3 old responses are dropped; first ins_pc after redirect is 32'h200; no stale data appears.
- Redirect in the same cycle as rsp_valid and as a pop → the popped instruction is delivered; the rsp is dropped; drop_cnt equals the remaining inflight.
- Assert reset mid-stream with the FIFO holding 2 entries → next cycle ins_valid=0, req_addr=RESET_PC, and fetch restarts at RESET_PC one cycle after reset falls.
